// File: rtl/reg_bus_master_if.sv
// Signal bundle between the host controller, reg_bus_master and the register bank.
// The master modport is the initiator's view; slave is the host/bank side.
interface reg_bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [1:0]  cmd_addr;
    logic [1:0]  cmd_len;
    logic [15:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_last;

    logic        sel;
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_wdata, rsp_ready, rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_last, sel, wr, addr, wdata
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_wdata, rsp_ready, rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_last, sel, wr, addr, wdata
    );
endinterface

// File: rtl/reg_bus_master.sv
// Command-driven initiator for the 4-entry, 16-bit register bank bus.
// Sequences one write or a 1..4 beat wrapping burst read per command, one response per beat.
module reg_bus_master #(
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    reg_bus_master_if.master  bus
);
    localparam int            LW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic        sel;
        logic        wr;
        logic [1:0]  addr;
        logic [15:0] wdata;
    } bus_t;

    state_t         state, state_nxt;
    bus_t           bus_q, bus_nxt;
    logic           wr_q;
    logic [1:0]     addr_q;
    logic [1:0]     beats_q;
    logic [15:0]    wdata_q;
    logic [15:0]    rdata_q;
    logic           last_q;
    logic [LW-1:0]  lat_cnt;
    logic           cmd_hs, rsp_hs, access_done;

    assign cmd_hs      = bus.cmd_valid && bus.cmd_ready;
    assign rsp_hs      = bus.rsp_valid && bus.rsp_ready;
    assign access_done = (state == ACCESS) && (wr_q || (lat_cnt == LAT_LAST));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_hs)      state_nxt = ACCESS;
            ACCESS:  if (access_done) state_nxt = RESP;
            RESP:    if (rsp_hs)      state_nxt = (beats_q != 2'd0) ? ACCESS : IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Bus values are computed for the coming cycle and registered, so no cmd_* path reaches the pins.
    always_comb begin
        bus.cmd_ready = (state == IDLE) && !reset;
        bus.rsp_valid = (state == RESP) && !reset;
        bus_nxt       = '0;
        if (state_nxt == ACCESS) begin
            case (state)
                IDLE:    bus_nxt = '{sel: 1'b1, wr: bus.cmd_wr, addr: bus.cmd_addr,
                                     wdata: bus.cmd_wr ? bus.cmd_wdata : 16'h0};
                ACCESS:  bus_nxt = '{sel: 1'b1, wr: wr_q, addr: addr_q, wdata: wdata_q};
                RESP:    bus_nxt = '{sel: 1'b1, wr: 1'b0, addr: addr_q + 2'd1, wdata: 16'h0};
                default: bus_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= 2'd0;
            beats_q <= 2'd0;
            wdata_q <= 16'h0;
            rdata_q <= 16'h0;
            last_q  <= 1'b0;
            lat_cnt <= '0;
        end else begin
            bus_q <= bus_nxt;
            case (state)
                IDLE: if (cmd_hs) begin
                    wr_q    <= bus.cmd_wr;
                    addr_q  <= bus.cmd_addr;
                    beats_q <= bus.cmd_wr ? 2'd0 : bus.cmd_len;
                    wdata_q <= bus.cmd_wr ? bus.cmd_wdata : 16'h0;
                    lat_cnt <= '0;
                end
                ACCESS: begin
                    if (access_done) begin
                        rdata_q <= wr_q ? 16'h0 : bus.rdata;
                        last_q  <= (beats_q == 2'd0);
                        lat_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                // The beat address advances on the response handshake, wrapping 3 -> 0.
                RESP: if (rsp_hs && (beats_q != 2'd0)) begin
                    addr_q  <= addr_q + 2'd1;
                    beats_q <= beats_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.sel       = bus_q.sel;
    assign bus.wr        = bus_q.wr;
    assign bus.addr      = bus_q.addr;
    assign bus.wdata     = bus_q.wdata;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_last  = last_q;
endmodule

// File: tb/tb_reg_bus_master.sv
// Randomized scoreboard bench for reg_bus_master with a behavioural register-bank model.
// Stimulus pushes expected bus accesses and responses; a negedge monitor pops and compares.
module tb_reg_bus_master;
    localparam int RD_LAT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   failures = 0;
    int   rsp_mode = 0;   // 0: rsp_ready high, 1: random, 2: held low

    reg_bus_master_if bus();

    reg_bus_master #(.RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Registered-read register bank: rdata follows addr one cycle later.
    logic [15:0] bank [4];
    logic [15:0] bank_rdata;
    always @(posedge clk) begin
        if (bus.sel && bus.wr) bank[bus.addr] <= bus.wdata;
        bank_rdata <= bank[bus.addr];
    end
    assign bus.rdata = bank_rdata;

    typedef struct { logic [15:0] rdata; logic last; } rsp_exp_t;
    typedef struct { logic wr; logic [1:0] addr; logic [15:0] wdata; } acc_exp_t;

    rsp_exp_t    rsp_q[$];
    acc_exp_t    acc_q[$];
    logic [15:0] ref_mem [4];

    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (rsp_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = ($urandom_range(0, 2) != 0);
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: bus accesses, responses, handshake timing and stall stability.
    initial begin : monitor
        int       trig_cyc, acc_start, outstanding;
        logic     sel_prev, rv_prev, stalled, held_last;
        logic [15:0] held_rdata;
        acc_exp_t cur;
        rsp_exp_t r;
        trig_cyc = 0; acc_start = 0; outstanding = 0;
        sel_prev = 0; rv_prev = 0; stalled = 0; held_last = 0; held_rdata = 0;
        cur = '{wr: 1'b0, addr: 2'd0, wdata: 16'h0};
        forever begin
            @(negedge clk);
            if (reset) begin
                rsp_q.delete();
                acc_q.delete();
                sel_prev = 0; rv_prev = 0; stalled = 0; outstanding = 0;
                check("cmd_ready_in_reset", bus.cmd_ready, 1'b0);
                check("rsp_valid_in_reset", bus.rsp_valid, 1'b0);
                continue;
            end
            check("cmd_ready_when_idle", bus.cmd_ready, outstanding == 0);
            if (bus.sel && !sel_prev) begin
                if (acc_q.size() == 0) check("spurious_bus_access", 1'b1, 1'b0);
                else begin
                    cur = acc_q.pop_front();
                    acc_start = cyc;
                    check("access_start_cycle", cyc, trig_cyc + 1);
                end
            end
            if (bus.sel) begin
                check("bus_wr", bus.wr, cur.wr);
                check("bus_addr", bus.addr, cur.addr);
                check("bus_wdata", bus.wdata, cur.wdata);
                check("sel_with_rsp_valid", bus.rsp_valid, 1'b0);
            end else begin
                check("bus_idle_fields", {bus.wr, bus.addr, bus.wdata}, 19'h0);
            end
            if (bus.rsp_valid && !rv_prev)
                check("rsp_latency", cyc - acc_start, cur.wr ? 1 : RD_LAT);
            if (stalled) begin
                check("stall_rsp_valid", bus.rsp_valid, 1'b1);
                check("stall_rsp_rdata", bus.rsp_rdata, held_rdata);
                check("stall_rsp_last", bus.rsp_last, held_last);
                check("stall_sel", bus.sel, 1'b0);
            end
            if (bus.rsp_valid) begin
                if (bus.rsp_ready) begin
                    if (rsp_q.size() == 0) check("spurious_response", 1'b1, 1'b0);
                    else begin
                        r = rsp_q.pop_front();
                        check("rsp_rdata", bus.rsp_rdata, r.rdata);
                        check("rsp_last", bus.rsp_last, r.last);
                    end
                    outstanding--;
                    trig_cyc = cyc;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held_rdata = bus.rsp_rdata;
                    held_last = bus.rsp_last;
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                outstanding += bus.cmd_wr ? 1 : int'(bus.cmd_len) + 1;
                trig_cyc = cyc;
            end
            sel_prev = bus.sel;
            rv_prev = bus.rsp_valid;
        end
    end

    // Called and returns at #1 after a rising edge.
    task automatic send_cmd(input logic w, input logic [1:0] a, input logic [1:0] l, input logic [15:0] d);
        int beats;
        int n;
        logic [1:0] ba;
        beats = w ? 1 : int'(l) + 1;
        for (int i = 0; i < beats; i++) begin
            ba = a + 2'(i);
            if (w) begin
                acc_q.push_back('{wr: 1'b1, addr: a, wdata: d});
                rsp_q.push_back('{rdata: 16'h0, last: 1'b1});
                ref_mem[a] = d;
            end else begin
                acc_q.push_back('{wr: 1'b0, addr: ba, wdata: 16'h0});
                rsp_q.push_back('{rdata: ref_mem[ba], last: (i == beats - 1)});
            end
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = w;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cmd_ready && n < 300);
        check("cmd_accepted_in_time", n < 300, 1'b1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || acc_q.size() != 0 || !bus.cmd_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drained_in_time", n < 1000, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 16'h0);
        check({tag, "_rsp_last"}, bus.rsp_last, 1'b0);
        check({tag, "_bus"}, {bus.sel, bus.wr, bus.addr, bus.wdata}, 20'h0);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [15:0] pat [4];
        int n;
        pat[0] = 16'hABCD; pat[1] = 16'h1234; pat[2] = 16'hDEAD; pat[3] = 16'hBEEF;
        bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = 2'd0;
        bus.cmd_len = 2'd0; bus.cmd_wdata = 16'h0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) send_cmd(1'b1, 2'(i), 2'(i), pat[i]);
        wait_idle();
        send_cmd(1'b0, 2'd0, 2'd3, 16'h0);
        wait_idle();
        send_cmd(1'b0, 2'd2, 2'd3, 16'h0);
        wait_idle();

        // Backpressure on the first beat for five cycles.
        rsp_mode = 2;
        send_cmd(1'b0, 2'd1, 2'd3, 16'h0);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 50);
        check("stall_rsp_seen", n < 50, 1'b1);
        repeat (4) @(negedge clk);
        @(posedge clk); #1 rsp_mode = 0;
        wait_idle();

        // Write queued behind a 4-beat read keeps cmd_valid high throughout.
        send_cmd(1'b0, 2'd0, 2'd3, 16'h0);
        send_cmd(1'b1, 2'd1, 2'd0, 16'h5A5A);
        wait_idle();

        // Reset during beat 2 of a burst, with a write offered in the reset cycle.
        send_cmd(1'b0, 2'd0, 2'd3, 16'h0);
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.rsp_valid && bus.rsp_ready) && n < 50);
        check("beat1_seen", n < 50, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 2'd3; bus.cmd_wdata = 16'h5555;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        repeat (3) @(posedge clk); #1;
        send_cmd(1'b0, 2'd1, 2'd0, 16'h0);
        wait_idle();
        send_cmd(1'b0, 2'd3, 2'd0, 16'h0);
        wait_idle();

        // Randomized traffic with random backpressure and idle gaps.
        rsp_mode = 1;
        for (int i = 0; i < 60; i++) begin
            send_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 16'($urandom));
            if ($urandom_range(0, 2) == 0) wait_idle();
        end
        wait_idle();
        rsp_mode = 0;
        for (int i = 0; i < 4; i++) send_cmd(1'b0, 2'(i), 2'd0, 16'h0);
        wait_idle();

        check("rsp_queue_empty", rsp_q.size(), 0);
        check("acc_queue_empty", acc_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
